axis_stall_detector: RTL and testbench

- Drives the per-channel `axis_block_sigs` vector consumed by the per-instance deadlock monitors in co-simulation.
- Watches the tvalid/tready pair of every AXI-Stream port of the DUT. Flags a channel as blocked once it has stalled for a programmable number of consecutive cycles.
- Records the first channel to trip, so the deadlock report can name the root stream.

---
 rtl/axis_stall_pkg.sv | 9 +
 rtl/axis_stall_ch.sv | 43 ++++
 rtl/axis_stall_detector.sv | 95 +++++++++
 tb/tb_axis_stall_detector.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/axis_stall_pkg.sv
// axis_stall_pkg: shared types and helpers for the AXI-Stream stall detector.
package axis_stall_pkg;
  localparam int CNT_W_DEF = 8;
  typedef enum logic {ARMED, TRIPPED} trip_state_e;
  // A consumer stalls when starved, a producer when back-pressured.
  function automatic logic stall_cond(input logic valid, input logic ready, input logic is_in);
    return is_in ? (ready & ~valid) : (valid & ~ready);
  endfunction
endpackage

// File: rtl/axis_stall_ch.sv
// axis_stall_ch: one saturating stall counter plus its registered block flag.
// AXIS_STALL_MAXLEN_EN exposes the next counter value for max-stall tracking.
module axis_stall_ch
  import axis_stall_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DEF,
  parameter int STALL_THRESH = 16,
  parameter bit IS_IN        = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_tvalid,
  input  logic             i_tready,
  input  logic             i_idle,
  output logic             o_block_nxt,
  output logic             o_block
`ifdef AXIS_STALL_MAXLEN_EN
  , output logic [CNT_W-1:0] o_cnt_nxt
`endif
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] THRESH  = CNT_W'(STALL_THRESH);
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_block;
  logic             w_stall;
  assign w_stall     = stall_cond(i_tvalid, i_tready, IS_IN);
  assign w_cnt_nxt   = (i_idle || !w_stall) ? '0 : (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
  assign o_block_nxt = w_cnt_nxt >= THRESH;
  assign o_block     = r_block;
`ifdef AXIS_STALL_MAXLEN_EN
  assign o_cnt_nxt   = w_cnt_nxt;
`endif
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_block <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_block <= o_block_nxt;
    end
  end
endmodule

// File: rtl/axis_stall_detector.sv
// axis_stall_detector: per-channel AXI-Stream stall flags with first-trip capture.
// AXIS_STALL_MAXLEN_EN adds o_max_stall, the longest stall seen since reset/clear.
module axis_stall_detector
  import axis_stall_pkg::*;
#(
  parameter int              NUM_CH       = 14,
  parameter logic [NUM_CH-1:0] IN_MASK    = 14'h000F,
  parameter int              STALL_THRESH = 16,
  parameter int              CNT_W        = CNT_W_DEF,
  localparam int             CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [NUM_CH-1:0] i_tvalid,
  input  logic [NUM_CH-1:0] i_tready,
  input  logic              i_inst_idle,
  input  logic              i_clear_trip,
  output logic [NUM_CH-1:0] o_axis_block_sigs,
  output logic              o_trip_valid,
  output logic [CH_W-1:0]   o_trip_ch
`ifdef AXIS_STALL_MAXLEN_EN
  , output logic [CNT_W-1:0] o_max_stall
`endif
);
  logic [NUM_CH-1:0] w_block_nxt;
  logic [CH_W-1:0]   w_first;
  logic              w_any;
  trip_state_e       r_state, w_state_nxt;
  logic [CH_W-1:0]   r_trip_ch, w_trip_ch_nxt;
`ifdef AXIS_STALL_MAXLEN_EN
  logic [CNT_W-1:0]  w_cnt_nxt [NUM_CH];
  logic [CNT_W-1:0]  r_max_stall, w_max_nxt;
`endif
  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_ch
      axis_stall_ch #(
        .CNT_W       (CNT_W),
        .STALL_THRESH(STALL_THRESH),
        .IS_IN       (IN_MASK[g])
      ) u_ch (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_tvalid   (i_tvalid[g]),
        .i_tready   (i_tready[g]),
        .i_idle     (i_inst_idle),
        .o_block_nxt(w_block_nxt[g]),
        .o_block    (o_axis_block_sigs[g])
`ifdef AXIS_STALL_MAXLEN_EN
        , .o_cnt_nxt(w_cnt_nxt[g])
`endif
      );
    end
  endgenerate
  // Descending scan so the lowest asserting index ends up winning.
  always_comb begin
    w_first = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) w_first = w_block_nxt[i] ? CH_W'(i) : w_first;
  end
  assign w_any = |w_block_nxt;
  // Clear has priority over a coincident trip.
  always_comb begin
    w_state_nxt   = r_state;
    w_trip_ch_nxt = r_trip_ch;
    if (i_clear_trip) begin
      w_state_nxt   = ARMED;
      w_trip_ch_nxt = '0;
    end else if (r_state == ARMED && w_any) begin
      w_state_nxt   = TRIPPED;
      w_trip_ch_nxt = w_first;
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ARMED;
      r_trip_ch <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_trip_ch <= w_trip_ch_nxt;
    end
  end
  assign o_trip_valid = r_state == TRIPPED;
  assign o_trip_ch    = r_trip_ch;
`ifdef AXIS_STALL_MAXLEN_EN
  always_comb begin
    w_max_nxt = r_max_stall;
    for (int i = 0; i < NUM_CH; i++) w_max_nxt = (w_cnt_nxt[i] > w_max_nxt) ? w_cnt_nxt[i] : w_max_nxt;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_max_stall <= '0;
    else          r_max_stall <= i_clear_trip ? '0 : w_max_nxt;
  end
  assign o_max_stall = r_max_stall;
`endif
endmodule

// File: tb/tb_axis_stall_detector.sv
// tb_axis_stall_detector: scoreboard bench with a run-length reference model.
module tb_axis_stall_detector;
  localparam int N = 14;
  localparam logic [N-1:0] INM = 14'h000F;
  localparam int TH = 16;
  localparam int SAT = 255;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] tvalid, tready, blk;
  logic idle, clr, tv;
  logic [3:0] tc;
  logic [7:0] ms;
  always #5 clk = ~clk;
  axis_stall_detector dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_tvalid(tvalid), .i_tready(tready),
    .i_inst_idle(idle), .i_clear_trip(clr), .o_axis_block_sigs(blk),
    .o_trip_valid(tv), .o_trip_ch(tc)
`ifdef AXIS_STALL_MAXLEN_EN
    , .o_max_stall(ms)
`endif
  );
`ifndef AXIS_STALL_MAXLEN_EN
  assign ms = 8'd0;
`endif
  typedef struct packed {
    logic [N-1:0] blk;
    logic         tv;
    logic [3:0]   tc;
    logic [7:0]   ms;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int run[N];
  logic m_tv;
  logic [3:0] m_tc;
  int m_ms;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [2*N-1:0] stall_vr(input logic [N-1:0] s);
    logic [N-1:0] v, r;
    for (int i = 0; i < N; i++) begin
      v[i] = s[i] ? !INM[i] : 1'b1;
      r[i] = s[i] ? INM[i] : 1'b1;
    end
    return {v, r};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) run[i] = 0;
    m_tv = 1'b0;
    m_tc = '0;
    m_ms = 0;
  endtask

  task automatic apply(input logic [N-1:0] v, input logic [N-1:0] r, input logic iv, input logic cv);
    exp_t e;
    int sat, mx, first;
    logic st;
    tvalid = v; tready = r; idle = iv; clr = cv;
    mx = 0; first = -1; e.blk = '0;
    for (int i = 0; i < N; i++) begin
      st = INM[i] ? (r[i] && !v[i]) : (v[i] && !r[i]);
      run[i] = (iv || !st) ? 0 : run[i] + 1;
      sat = (run[i] > SAT) ? SAT : run[i];
      e.blk[i] = sat >= TH;
      if (e.blk[i] && first < 0) first = i;
      if (sat > mx) mx = sat;
    end
    if (cv) begin
      m_tv = 1'b0;
      m_tc = '0;
    end else if (!m_tv && first >= 0) begin
      m_tv = 1'b1;
      m_tc = 4'(first);
    end
    m_ms = cv ? 0 : (mx > m_ms ? mx : m_ms);
    e.tv = m_tv; e.tc = m_tc; e.ms = 8'(m_ms);
    q.push_back(e);
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] r, input logic iv, input logic cv);
    @(negedge clk);
    apply(v, r, iv, cv);
  endtask

  task automatic stall(input logic [N-1:0] s, input int n, input logic iv = 1'b0, input logic cv = 1'b0);
    logic [N-1:0] v, r;
    {v, r} = stall_vr(s);
    repeat (n) drive(v, r, iv, cv);
  endtask

  task automatic pulse_reset(input logic [N-1:0] s);
    logic [N-1:0] v, r;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rst_block", 32'(blk), 0);
    check("async_rst_trip_valid", 32'(tv), 0);
    check("async_rst_trip_ch", 32'(tc), 0);
    #1 rst_n = 1'b1;
    model_reset();
    {v, r} = stall_vr(s);
    apply(v, r, 1'b0, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("block_sigs", 32'(blk), 32'(e.blk));
        check("trip_valid", 32'(tv), 32'(e.tv));
        check("trip_ch", 32'(tc), 32'(e.tc));
`ifdef AXIS_STALL_MAXLEN_EN
        check("max_stall", 32'(ms), 32'(e.ms));
`endif
      end
    end
  end

  initial begin : driver
    logic [N-1:0] mode, v, r;
    tvalid = '1; tready = '1; idle = 1'b0; clr = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_block", 32'(blk), 0);
    check("reset_trip_valid", 32'(tv), 0);
    check("reset_trip_ch", 32'(tc), 0);
    rst_n = 1'b1;
    stall(14'(1 << 5), 16);
    stall('0, 2);
    stall('0, 1, 1'b0, 1'b1);
    stall(14'(1 << 2), 15);
    stall('0, 1);
    stall(14'(1 << 2), 15);
    stall('0, 2);
    stall(14'((1 << 3) | (1 << 9)), 16);
    stall('0, 1);
    stall(14'(1 << 9), 20);
    stall(14'(1 << 9), 1, 1'b0, 1'b1);
    stall(14'(1 << 9), 2);
    stall('0, 1, 1'b0, 1'b1);
    stall(14'(1 << 7), 300);
    stall(14'(1 << 7), 1, 1'b1, 1'b0);
    stall(14'(1 << 7), 3);
    stall('0, 1, 1'b0, 1'b1);
    stall(14'(1 << 5), 10);
    pulse_reset(14'(1 << 5));
    stall(14'(1 << 5), 20);
    stall('0, 1, 1'b0, 1'b1);
`ifdef AXIS_STALL_MAXLEN_EN
    stall(14'(1 << 0), 40);
    stall(14'(1 << 1), 25);
    stall('0, 2);
    stall('0, 1, 1'b0, 1'b1);
    stall('0, 1);
`endif
    mode = '0;
    repeat (2000) begin
      for (int i = 0; i < N; i++) if ($urandom_range(0, 24) == 0) mode[i] = ~mode[i];
      {v, r} = stall_vr(mode);
      for (int i = 0; i < N; i++) begin
        if (!mode[i]) begin
          case ($urandom_range(0, 2))
            0: begin v[i] = 1'b1; r[i] = 1'b1; end
            1: begin v[i] = 1'b0; r[i] = 1'b0; end
            default: begin v[i] = 1'($urandom); r[i] = 1'($urandom); end
          endcase
        end
      end
      drive(v, r, $urandom_range(0, 99) == 0, $urandom_range(0, 39) == 0);
    end
    repeat (2) @(negedge clk);
    check("queue_drain", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
